// File: rtl/regbank_port_scheduler.sv
// Shares the 16x32 register bank between the pipeline and a host/debug port,
// with a pending-writeback scoreboard and bounded-wait host arbitration.
module regbank_port_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int HOST_MAX_WAIT = 8,
    parameter int WAIT_CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sb_set,
    input  logic [ADDR_WIDTH-1:0] sb_addr,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rd_resp_valid,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  reg_rd,
    output logic [ADDR_WIDTH-1:0] address_ra,
    output logic [ADDR_WIDTH-1:0] address_rb,
    output logic                  reg_wr,
    output logic [ADDR_WIDTH-1:0] address_wr,
    output logic [DATA_WIDTH-1:0] data_wr,
    input  logic [DATA_WIDTH-1:0] data_outA,
    input  logic [DATA_WIDTH-1:0] data_outB,
    output logic [(1<<ADDR_WIDTH)-1:0] pending
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT = WAIT_CNT_W'(HOST_MAX_WAIT);

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [WAIT_CNT_W-1:0] host_wait_q, host_wait_d;
    logic                  reg_rd_q, reg_rd_d;
    logic                  rd_host_q, rd_host_d;
    logic [ADDR_WIDTH-1:0] address_ra_q, address_ra_d;
    logic [ADDR_WIDTH-1:0] address_rb_q, address_rb_d;
    logic                  reg_wr_q, reg_wr_d;
    logic [ADDR_WIDTH-1:0] address_wr_q, address_wr_d;
    logic [DATA_WIDTH-1:0] data_wr_q, data_wr_d;
    logic                  rd_resp_valid_q, rd_resp_valid_d;
    logic                  host_rvalid_q, host_rvalid_d;

    logic host_rd_req, host_wr_req, host_force, rd_elig;
    logic rd_grant, host_rd_grant, wb_ready_c, wb_grant, host_wr_grant;

    // Grants: pipeline/writeback win unless the host has waited the full budget.
    always_comb begin
        host_rd_req   = host_valid & ~host_we;
        host_wr_req   = host_valid & host_we;
        host_force    = (host_wait_q == MAX_WAIT);
        rd_elig       = rd_valid & ~pending_q[rd_addr_a] & ~pending_q[rd_addr_b];
        rd_grant      = ~rst & rd_elig & ~(host_rd_req & host_force);
        host_rd_grant = ~rst & host_rd_req & (host_force | ~rd_elig);
        wb_ready_c    = ~rst & ~(host_wr_req & host_force);
        wb_grant      = wb_valid & wb_ready_c;
        host_wr_grant = ~rst & host_wr_req & (host_force | ~wb_valid);
    end

    assign rd_ready   = rd_grant;
    assign wb_ready   = wb_ready_c;
    assign host_ready = host_rd_grant | host_wr_grant;

    always_comb begin
        pending_d       = pending_q;
        host_wait_d     = host_wait_q;
        reg_rd_d        = rd_grant | host_rd_grant;
        rd_host_d       = host_rd_grant;
        address_ra_d    = address_ra_q;
        address_rb_d    = address_rb_q;
        reg_wr_d        = wb_grant | host_wr_grant;
        address_wr_d    = address_wr_q;
        data_wr_d       = data_wr_q;
        rd_resp_valid_d = reg_rd_q & ~rd_host_q;
        host_rvalid_d   = reg_rd_q & rd_host_q;

        // Set is applied after clear so a same-edge reservation survives.
        if (wb_grant)
            pending_d[wb_addr] = 1'b0;
        if (sb_set)
            pending_d[sb_addr] = 1'b1;

        if (!host_valid || host_ready)
            host_wait_d = '0;
        else if (!host_force)
            host_wait_d = host_wait_q + WAIT_CNT_W'(1);

        if (rd_grant) begin
            address_ra_d = rd_addr_a;
            address_rb_d = rd_addr_b;
        end else if (host_rd_grant) begin
            address_ra_d = host_addr;
            address_rb_d = host_addr;
        end

        if (wb_grant) begin
            address_wr_d = wb_addr;
            data_wr_d    = wb_data;
        end else if (host_wr_grant) begin
            address_wr_d = host_addr;
            data_wr_d    = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q       <= '0;
            host_wait_q     <= '0;
            reg_rd_q        <= 1'b0;
            rd_host_q       <= 1'b0;
            address_ra_q    <= '0;
            address_rb_q    <= '0;
            reg_wr_q        <= 1'b0;
            address_wr_q    <= '0;
            data_wr_q       <= '0;
            rd_resp_valid_q <= 1'b0;
            host_rvalid_q   <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            host_wait_q     <= host_wait_d;
            reg_rd_q        <= reg_rd_d;
            rd_host_q       <= rd_host_d;
            address_ra_q    <= address_ra_d;
            address_rb_q    <= address_rb_d;
            reg_wr_q        <= reg_wr_d;
            address_wr_q    <= address_wr_d;
            data_wr_q       <= data_wr_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            host_rvalid_q   <= host_rvalid_d;
        end
    end

    assign pending    = pending_q;
    assign reg_rd     = reg_rd_q;
    assign address_ra = address_ra_q;
    assign address_rb = address_rb_q;
    assign reg_wr     = reg_wr_q;
    assign address_wr = address_wr_q;
    assign data_wr    = data_wr_q;

    // The bank presents its captured data during the response cycle itself.
    assign rd_resp_valid = rd_resp_valid_q;
    assign host_rvalid   = host_rvalid_q;
    assign rd_data_a     = rd_resp_valid_q ? data_outA : '0;
    assign rd_data_b     = rd_resp_valid_q ? data_outB : '0;
    assign host_rdata    = host_rvalid_q ? data_outA : '0;

endmodule

// File: tb/tb_regbank_port_scheduler.sv
// Vector table plus scoreboard bench for regbank_port_scheduler, with a
// behavioural 16x32 bank (posedge read, negedge write) attached.
module tb_regbank_port_scheduler;

    typedef struct {
        logic        rst;
        logic        sb_set;
        logic [3:0]  sb_addr;
        logic        rd_valid;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        wb_valid;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        hv;
        logic        hwe;
        logic [3:0]  ha;
        logic [31:0] hd;
        logic        e_rdr;
        logic        e_wbr;
        logic        e_hr;
        logic [15:0] e_pend;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, sb_set, rd_valid, wb_valid, host_valid, host_we;
    logic [3:0]  sb_addr, rd_addr_a, rd_addr_b, wb_addr, host_addr;
    logic [31:0] wb_data, host_wdata;
    logic        rd_ready, rd_resp_valid, wb_ready, host_ready, host_rvalid;
    logic [31:0] rd_data_a, rd_data_b, host_rdata;
    logic        reg_rd, reg_wr;
    logic [3:0]  address_ra, address_rb, address_wr;
    logic [31:0] data_wr, data_outA, data_outB;
    logic [15:0] pending;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        preload;

    exp_t bank_rd_q[$], bank_wr_q[$], rd_resp_q[$], host_resp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   prev_rst = 1'b0;

    always #5 clk = ~clk;

    regbank_port_scheduler dut (
        .clk(clk), .rst(rst), .sb_set(sb_set), .sb_addr(sb_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_resp_valid(rd_resp_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .reg_rd(reg_rd), .address_ra(address_ra),
        .address_rb(address_rb), .reg_wr(reg_wr), .address_wr(address_wr),
        .data_wr(data_wr), .data_outA(data_outA), .data_outB(data_outB), .pending(pending)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 3) return 32'h11;
        if (i == 5) return 32'h22;
        return 32'h100 + 32'(i);
    endfunction

    // Register bank model: captures read addresses on posedge, writes on negedge.
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (reg_wr) begin
            mem[address_wr] <= data_wr;
        end
    end

    always @(posedge clk) begin
        if (reg_rd) begin
            data_outA <= mem[address_ra];
            data_outB <= mem[address_rb];
        end
    end

    function automatic vec_t mk(input int rst_i, input int sbs, input int sba, input int rdv,
                                input int ra, input int rb, input int wbv, input int wa,
                                input logic [31:0] wd, input int hv, input int hwe,
                                input int ha, input logic [31:0] hd, input int e_rdr,
                                input int e_wbr, input int e_hr, input logic [15:0] e_pend);
        vec_t v;
        v.rst = 1'(rst_i);   v.sb_set = 1'(sbs);  v.sb_addr = 4'(sba);
        v.rd_valid = 1'(rdv); v.ra = 4'(ra);       v.rb = 4'(rb);
        v.wb_valid = 1'(wbv); v.wa = 4'(wa);       v.wd = wd;
        v.hv = 1'(hv);       v.hwe = 1'(hwe);     v.ha = 4'(ha);  v.hd = hd;
        v.e_rdr = 1'(e_rdr); v.e_wbr = 1'(e_wbr); v.e_hr = 1'(e_hr);
        v.e_pend = e_pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst        = v.rst;
        sb_set     = v.sb_set;
        sb_addr    = v.sb_addr;
        rd_valid   = v.rd_valid;
        rd_addr_a  = v.ra;
        rd_addr_b  = v.rb;
        wb_valid   = v.wb_valid;
        wb_addr    = v.wa;
        wb_data    = v.wd;
        host_valid = v.hv;
        host_we    = v.hwe;
        host_addr  = v.ha;
        host_wdata = v.hd;
    endtask

    task automatic checkOutput(input vec_t v);
        bit   due;
        exp_t e;
        #2;
        check("rd_ready", 32'(rd_ready), 32'(v.e_rdr));
        check("wb_ready", 32'(wb_ready), 32'(v.e_wbr));
        check("host_ready", 32'(host_ready), 32'(v.e_hr));
        check("pending", 32'(pending), 32'(v.e_pend));

        if (prev_rst) begin
            check("rst_addr", 32'({address_ra, address_rb, address_wr}), 32'h0);
            check("rst_data_wr", data_wr, 32'h0);
            check("rst_rdata", rd_data_a | rd_data_b | host_rdata, 32'h0);
        end

        due = bank_rd_q.size() != 0 && bank_rd_q[0].due == cyc;
        check("reg_rd", 32'(reg_rd), 32'(due));
        if (due) begin
            e = bank_rd_q.pop_front();
            check("address_ra", 32'(address_ra), e.a);
            check("address_rb", 32'(address_rb), e.b);
        end

        due = bank_wr_q.size() != 0 && bank_wr_q[0].due == cyc;
        check("reg_wr", 32'(reg_wr), 32'(due));
        if (due) begin
            e = bank_wr_q.pop_front();
            check("address_wr", 32'(address_wr), e.a);
            check("data_wr", data_wr, e.b);
        end

        due = rd_resp_q.size() != 0 && rd_resp_q[0].due == cyc;
        check("rd_resp_valid", 32'(rd_resp_valid), 32'(due));
        if (due) begin
            e = rd_resp_q.pop_front();
            check("rd_data_a", rd_data_a, e.a);
            check("rd_data_b", rd_data_b, e.b);
        end

        due = host_resp_q.size() != 0 && host_resp_q[0].due == cyc;
        check("host_rvalid", 32'(host_rvalid), 32'(due));
        if (due) begin
            e = host_resp_q.pop_front();
            check("host_rdata", host_rdata, e.a);
        end

        // Reads are scored against the reference before same-edge writes land.
        if (v.rd_valid && rd_ready) begin
            bank_rd_q.push_back('{cyc + 1, 32'(v.ra), 32'(v.rb)});
            rd_resp_q.push_back('{cyc + 2, ref_mem[v.ra], ref_mem[v.rb]});
        end
        if (v.hv && !v.hwe && host_ready) begin
            bank_rd_q.push_back('{cyc + 1, 32'(v.ha), 32'(v.ha)});
            host_resp_q.push_back('{cyc + 2, ref_mem[v.ha], 32'h0});
        end
        if (v.wb_valid && wb_ready) begin
            bank_wr_q.push_back('{cyc + 1, 32'(v.wa), v.wd});
            ref_mem[v.wa] = v.wd;
        end
        if (v.hv && v.hwe && host_ready) begin
            bank_wr_q.push_back('{cyc + 1, 32'(v.ha), v.hd});
            ref_mem[v.ha] = v.hd;
        end

        if (v.rst) begin
            bank_rd_q.delete();
            bank_wr_q.delete();
            rd_resp_q.delete();
            host_resp_q.delete();
        end
        prev_rst = v.rst;
        cyc++;
    endtask

    task automatic run(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        preload = 1'b1;
        v = mk(1, 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 16'h0);
        applyStimulus(v);
        repeat (2) @(negedge clk);
        preload  = 1'b0;
        prev_rst = 1'b1;

        //        rst sb sa rdv ra rb wbv wa wd           hv we ha hd          rdr wbr hr pend
        tbl.push_back(mk(1, 1,6, 1,3,5, 1,1,32'h1,       1,0,2,32'h0,        0,0,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 1,3,5, 0,0,32'h0,       0,0,0,32'h0,        1,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 1,7, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 1,7,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0080));
        tbl.push_back(mk(0, 0,0, 1,7,0, 1,7,32'hABCD,    0,0,0,32'h0,        0,1,0, 16'h0080));
        tbl.push_back(mk(0, 0,0, 1,7,0, 0,0,32'h0,       0,0,0,32'h0,        1,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 1,4, 0,0,0, 1,4,32'h44,      0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0010));
        tbl.push_back(mk(0, 0,0, 0,0,0, 1,4,32'h55,      0,0,0,32'h0,        0,1,0, 16'h0010));
        tbl.push_back(mk(0, 1,2, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 1,0,2, 0,0,32'h0,       1,0,3,32'h0,        0,1,1, 16'h0004));
        tbl.push_back(mk(0, 0,0, 1,3,5, 0,0,32'h0,       0,0,0,32'h0,        1,1,0, 16'h0004));
        tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,0,0, 16'h0004));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       1,0,5,32'h0,        0,1,1, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       1,1,6,32'h66,       0,1,1, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 1,6,5, 0,0,32'h0,       0,0,0,32'h0,        1,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));
        tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,32'h0,       0,0,0,32'h0,        0,1,0, 16'h0000));

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // Host read starved by back-to-back pipeline reads: forced on the 9th
        // attempt, and the counter restarts so the next request waits 8 again.
        for (int i = 1; i <= 18; i++) begin
            bit acc;
            acc = (i == 9) || (i == 18);
            run(mk(0, 0,0, 1,1,2, 0,0,32'h0, 1,0,(i <= 9) ? 15 : 14,32'h0,
                   acc ? 0 : 1, 1, acc ? 1 : 0, 16'h0000));
        end
        repeat (2) run(mk(0, 0,0, 0,0,0, 0,0,32'h0, 0,0,0,32'h0, 0,1,0, 16'h0000));

        // Host write against continuous writebacks; a dropped host_valid
        // restarts the wait, and the host write leaves pending[9] alone.
        for (int i = 0; i <= 12; i++) begin
            run(mk(0, (i == 0) ? 1 : 0,9, 0,0,0, 1,i % 4,32'h1000 + 32'(i),
                   (i == 3) ? 0 : 1,1,9,32'h5,
                   0, (i == 12) ? 0 : 1, (i == 12) ? 1 : 0,
                   (i == 0) ? 16'h0000 : 16'h0200));
        end
        repeat (2) run(mk(0, 0,0, 0,0,0, 0,0,32'h0, 0,0,0,32'h0, 0,1,0, 16'h0200));

        check("drain", 32'(bank_rd_q.size() + bank_wr_q.size() + rd_resp_q.size() + host_resp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
